// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes, field positions and fetch state type
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int PC_W = 16;
  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RR1_HI = 11;
  localparam int RR1_LO = 8;
  localparam int RR2_HI = 7;
  localparam int RR2_LO = 4;
  typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/ifid_buffer.sv
// ifid_buffer: IF/ID pipeline register with flush, hold and decode field slices
module ifid_buffer import cpu_pkg::*; #(
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               hold,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc1_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc1,
  output logic               valid,
  output logic [3:0]         opcode,
  output logic [3:0]         rr1,
  output logic [3:0]         rr2
);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      instr <= INSTR_W'(NOP_INSTR);
      pc1 <= '0;
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr <= instr_in;
      pc1 <= pc1_in;
      valid <= 1'b1;
    end
  end
  assign opcode = instr[OPC_HI:OPC_LO];
  assign rr1 = instr[RR1_HI:RR1_LO];
  assign rr2 = instr[RR2_HI:RR2_LO];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, halt FSM and fetch counter
module fetch_stage import cpu_pkg::*; #(
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int PC_W = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_pc,
  input  logic               pc_halt,
  input  logic               bIFID_stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc1,
  output logic               ifid_valid,
  output logic [3:0]         ifid_opcode,
  output logic [3:0]         ifid_rr1,
  output logic [3:0]         ifid_rr2,
  output logic               halted,
  output logic [31:0]        fetch_count
);
  fetch_state_t state, state_next;
  logic [PC_W-1:0] pc, pc_inc, pc_next;
  logic run, do_branch, do_fetch, hold;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else state <= state_next;
  end
  always_comb state_next = (state == RUN && pc_halt) ? HALTED : state;
  always_comb halted = (state == HALTED);
  assign run = (state == RUN) && !pc_halt;
  assign do_branch = run && branch_taken;
  assign hold = !run || bIFID_stall || !pc_pc;
  assign do_fetch = !do_branch && !hold;
  assign pc_inc = pc + PC_W'(1);
  always_comb pc_next = do_branch ? branch_target : do_fetch ? pc_inc : pc;
  always_ff @(posedge clk) begin
    if (!rst_n) pc <= RESET_PC;
    else pc <= pc_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) fetch_count <= '0;
    else if (do_fetch && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
  end
  assign imem_addr = pc;
  ifid_buffer #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_ifid (
    .clk(clk),
    .rst_n(rst_n),
    .load(run),
    .hold(hold),
    .flush(do_branch),
    .instr_in(imem_rdata),
    .pc1_in(pc_inc),
    .instr(ifid_instr),
    .pc1(ifid_pc1),
    .valid(ifid_valid),
    .opcode(ifid_opcode),
    .rr1(ifid_rr1),
    .rr2(ifid_rr2)
  );
endmodule
